// File: rtl/vga_pkg.sv
// Shared VGA constants and the timing bundle passed between pixel-pipeline stages.
package vga_pkg;

  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;

  localparam logic [11:0] RGB_PIPE   = 12'h0_A_0;
  localparam logic [11:0] RGB_BORDER = 12'h0_4_0;
  localparam logic [11:0] RGB_END    = 12'hA_0_0;

  typedef struct packed {
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
  } vga_timing_t;

  localparam int TIMING_W = $bits(vga_timing_t);

endpackage

// File: rtl/delay.sv
// Fixed-length register chain used to keep side-band signals aligned with the datapath.
module delay #(
  parameter int WIDTH   = 1,
  parameter int CLK_DEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [CLK_DEL];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CLK_DEL; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din_i;
      for (int i = 1; i < CLK_DEL; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout_o = stage_q[CLK_DEL-1];

endmodule

// File: rtl/draw_obstacle.sv
// Overlays a two-part pipe (top and bottom, with a gap) onto the VGA pixel stream.
// Obstacle position is captured once per frame on the rising edge of vblnk.
module draw_obstacle
  import vga_pkg::*;
#(
  parameter int          OBST_WIDTH = 60,
  parameter int          BORDER     = 2,
  parameter logic [11:0] PIPE_RGB   = RGB_PIPE,
  parameter logic [11:0] BORDER_RGB = RGB_BORDER,
  parameter logic [11:0] END_RGB    = RGB_END
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] obstacle_xpos_1,
  input  logic [11:0] obstacle_ypos_1,
  input  logic [11:0] obstacle_ypos_2,
  input  logic        endgame,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [12:0] HOR13 = 13'(HOR_PIXELS);
  localparam logic [12:0] W13   = 13'(OBST_WIDTH);
  localparam logic [12:0] B13   = 13'(BORDER);

  // Frame latch
  logic        vblnk_prev_q;
  logic        vblnk_rise;
  logic [11:0] x_q, y1_q, y2_q;
  logic        end_q;

  assign vblnk_rise = vblnk_in & ~vblnk_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_prev_q <= 1'b0;
      x_q          <= 12'(HOR_PIXELS);
      y1_q         <= 12'd0;
      y2_q         <= 12'(VER_PIXELS);
      end_q        <= 1'b0;
    end else begin
      vblnk_prev_q <= vblnk_in;
      if (vblnk_rise) begin
        x_q   <= obstacle_xpos_1;
        y1_q  <= obstacle_ypos_1;
        y2_q  <= obstacle_ypos_2;
        end_q <= endgame;
      end
    end
  end

  // Stage 1: hit flags
  logic [12:0] hc13, vc13, x13, y1_13, y2_13, x_right, x_clip;
  logic        degen, edge_lr, edge_gap;
  logic        in_x_d, in_top_d, in_bot_d, on_border_d;
  logic        in_x_q, in_top_q, in_bot_q, on_border_q;

  assign hc13    = {2'b00, hcount_in};
  assign vc13    = {2'b00, vcount_in};
  assign x13     = {1'b0, x_q};
  assign y1_13   = {1'b0, y1_q};
  assign y2_13   = {1'b0, y2_q};
  assign x_right = x13 + W13 - 13'd1;
  assign x_clip  = (x_right > HOR13 - 13'd1) ? HOR13 - 13'd1 : x_right;
  // With y1 >= y2 the top and bottom pipes merge, so there is no gap edge to outline.
  assign degen   = (y1_13 >= y2_13);

  always_comb begin
    in_x_d      = (x13 < HOR13) && (hc13 >= x13) && (hc13 <= x_clip);
    in_top_d    = (vc13 <= y1_13);
    in_bot_d    = (vc13 >= y2_13);
    edge_lr     = (hc13 < x13 + B13) || (hc13 + B13 > x_clip);
    edge_gap    = !degen && ((in_top_d && (vc13 + B13 > y1_13)) ||
                             (in_bot_d && (vc13 < y2_13 + B13)));
    on_border_d = in_x_d && (in_top_d || in_bot_d) && (edge_lr || edge_gap);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_x_q      <= 1'b0;
      in_top_q    <= 1'b0;
      in_bot_q    <= 1'b0;
      on_border_q <= 1'b0;
    end else begin
      in_x_q      <= in_x_d;
      in_top_q    <= in_top_d;
      in_bot_q    <= in_bot_d;
      on_border_q <= on_border_d;
    end
  end

  // Side-band alignment: blanking+rgb travel one stage, timing travels both stages.
  logic [13:0]  pix_s1;
  vga_timing_t  tim_in, tim_out;

  assign tim_in = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                    vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in};

  delay #(.WIDTH(14), .CLK_DEL(1)) u_pix_delay (
    .clk    (clk),
    .rst    (rst),
    .din_i  ({hblnk_in, vblnk_in, rgb_in}),
    .dout_o (pix_s1)
  );

  delay #(.WIDTH(TIMING_W), .CLK_DEL(2)) u_tim_delay (
    .clk    (clk),
    .rst    (rst),
    .din_i  (tim_in),
    .dout_o (tim_out)
  );

  // Stage 2: colour select
  logic [11:0] rgb_out_d, rgb_out_q;

  always_comb begin
    rgb_out_d = pix_s1[11:0];
    if (!(pix_s1[13] || pix_s1[12])) begin
      if (on_border_q)
        rgb_out_d = BORDER_RGB;
      else if (in_x_q && (in_top_q || in_bot_q))
        rgb_out_d = end_q ? END_RGB : PIPE_RGB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rgb_out_q <= 12'h000;
    else     rgb_out_q <= rgb_out_d;
  end

  assign rgb_out    = rgb_out_q;
  assign hcount_out = tim_out.hcount;
  assign hsync_out  = tim_out.hsync;
  assign hblnk_out  = tim_out.hblnk;
  assign vcount_out = tim_out.vcount;
  assign vsync_out  = tim_out.vsync;
  assign vblnk_out  = tim_out.vblnk;

endmodule

// File: doc/draw_obstacle.md
Name: draw_obstacle

Overview:
- VGA pixel-pipeline stage directly downstream of draw_obstacle_ctl.
- Consumes the obstacle position (x, top-pipe bottom edge, bottom-pipe top edge) and the endgame flag, and overlays a two-part pipe onto the incoming 800x600 @ 40 MHz pixel stream.
- Positions are frame-latched during vertical blanking so a pipe never tears mid-frame.
- Sits between the background/rect drawing stages and the VGA output register.

Parameters:
- OBST_WIDTH, 60, pipe width in pixels.
- BORDER, 2, outline thickness in pixels; drawn on left/right edges and the gap-facing edges.
- PIPE_RGB, 12'h0_A_0, pipe fill colour.
- BORDER_RGB, 12'h0_4_0, outline colour.
- END_RGB, 12'hA_0_0, fill colour while endgame is latched.

Ports:
- clk  in  1  40 MHz pixel clock.
- rst  in  1  synchronous active-high reset.
- hcount_in  in  11  pixel column.
- hsync_in  in  1  horizontal sync.
- hblnk_in  in  1  horizontal blank.
- vcount_in  in  11  pixel row.
- vsync_in  in  1  vertical sync.
- vblnk_in  in  1  vertical blank.
- rgb_in  in  12  upstream pixel colour.
- obstacle_xpos_1  in  12  pipe left edge, unsigned screen x.
- obstacle_ypos_1  in  12  last row of the top pipe.
- obstacle_ypos_2  in  12  first row of the bottom pipe.
- endgame  in  1  game-over flag from draw_obstacle_ctl.
- hcount_out  out  11  timing delayed by 2.
- hsync_out  out  1  timing delayed by 2.
- hblnk_out  out  1  timing delayed by 2.
- vcount_out  out  11  timing delayed by 2.
- vsync_out  out  1  timing delayed by 2.
- vblnk_out  out  1  timing delayed by 2.
- rgb_out  out  12  composited pixel.

Behaviour:
- Reset is synchronous and active-high, on clk. Everything below happens on the rising edge of clk.
- Reset values:
  - All outputs are 0.
  - Latched x = HOR_PIXELS (pipe off-screen).
  - Latched y1 = 0, latched y2 = VER_PIXELS.
  - Latched endgame = 0.
- Frame latch:
  - On the rising edge of vblnk_in (registered previous value 0, current value 1), the block captures xpos, ypos_1, ypos_2 and endgame.
  - The captured values stay constant for the whole next active frame.
  - Input changes at any other time have no effect until the next vblnk rise.
- Pipeline, latency exactly 2 cycles for every output:
  - Stage 1 registers the hit flags: in_x, in_top, in_bot and on_border.
  - Stage 2 selects the colour.
  - All timing signals are delayed 2 cycles, aligned with rgb_out.
- Geometry, computed in 13 bits to avoid overflow:
  - in_x when latched_x <= hcount <= min(latched_x + OBST_WIDTH - 1, HOR_PIXELS - 1).
  - in_top when vcount <= y1.
  - in_bot when vcount >= y2.
  - pipe = in_x && (in_top || in_bot).
  - latched_x >= HOR_PIXELS means nothing is drawn.
- Border:
  - A pixel is on the border if it is a pipe pixel and lies within BORDER px of the left edge, the right edge (clipped), or the gap edges (y1 - BORDER + 1 .. y1, or y2 .. y2 + BORDER - 1).
- Degenerate gap: if y1 >= y2, the whole column is pipe. Border applies to left/right edges only.
- Colour priority, highest first:
  1. Blanking (hblnk or vblnk delayed) gives rgb_out = rgb delayed, untouched.
  2. Border gives BORDER_RGB.
  3. Pipe fill gives END_RGB if latched endgame, else PIPE_RGB.
  4. Otherwise rgb delayed.
- Reset mid-frame: outputs go to 0 on the next edge. Drawing is suppressed until the first vblnk rise after reset is released.

Decomposition:
- vga_pkg (shared) holds HOR_PIXELS = 800, VER_PIXELS = 600, the colour constants and the struct/typedef for the timing bundle (hcount, hsync, hblnk, vcount, vsync, vblnk).
- One sub-module, delay (parameters WIDTH, CLK_DEL = 2), carries the timing bundle and rgb_in alongside the datapath.

Test Plan:
1. Reset held, then released; inputs x=300, y1=200, y2=350 applied mid-frame.
   - rgb_out equals the input rgb for the rest of the frame.
   - From the next frame, pixel (310,100) = PIPE_RGB, (310,250) = rgb_in, (310,400) = PIPE_RGB.
2. Border check, with x=300, y1=200, y2=350, BORDER=2.
   - (300,100) and (301,100) = BORDER_RGB; (302,100) = PIPE_RGB; (359,100) = BORDER_RGB; (360,100) = rgb_in.
   - (330,199) and (330,200) = BORDER_RGB; (330,350) = BORDER_RGB.
3. Latency check: a single-pixel rgb_in marker at hcount=10 appears on rgb_out exactly 2 cycles later, with hcount_out=10.
4. Right-edge clipping: x=770 draws columns 770..799 only; x=800 draws nothing on any row.
5. endgame=1 asserted mid-frame.
   - The fill stays PIPE_RGB until the vblnk rise.
   - The next frame's fill = END_RGB; the border stays BORDER_RGB.
6. Degenerate gap: y1=400, y2=300 gives full column 300..359 drawn on all rows 0..599; rst pulsed at row 250 gives rgb_out = 0 on the next cycle.
